// File: rtl/foo_seq_checker.sv
// foo_seq_checker: receive-side checker for an incrementing foo_if data stream.
// Optional console trace guarded by macro FOO_SEQ_CHECKER_DISPLAY_EN.
module foo_seq_checker #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              locked,
    output logic              mismatch,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [DATA_W-1:0] first_exp,
    output logic [DATA_W-1:0] first_act
);

    localparam int MC_W = 4;
    localparam logic [MC_W-1:0] LOCK_TGT = MC_W'(LOCK_N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_expected;
    logic [MC_W-1:0]   r_match_cnt;
    logic              r_locked;
    logic              r_mismatch;
    logic              r_err_sticky;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [DATA_W-1:0] r_first_exp;
    logic [DATA_W-1:0] r_first_act;

    logic              w_take;
    logic              w_match;
    logic [DATA_W-1:0] w_next_exp;
    logic [MC_W-1:0]   w_match_nxt;
    logic              w_lock_evt;
    logic              w_err_evt;
    logic              w_word_sat;
    logic              w_err_sat;

    // A word is only consumed when not being cleared in the same cycle
    assign w_take      = data_valid && !clr;
    assign w_match     = (data_in == r_expected);
    assign w_next_exp  = data_in + DATA_W'(1);
    assign w_match_nxt = r_match_cnt + MC_W'(1);
    assign w_lock_evt  = w_take && (r_state == S_SYNC)
                         && w_match && (w_match_nxt == LOCK_TGT);
    assign w_err_evt   = w_take && (r_state == S_LOCKED) && !w_match;
    assign w_word_sat  = (r_word_cnt == {CNT_W{1'b1}});
    assign w_err_sat   = (r_err_cnt == {CNT_W{1'b1}});

    // Sequence FSM: anchor in IDLE, count matches in SYNC, track in LOCKED
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_expected  <= '0;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
        end else if (clr) begin
            r_state     <= S_IDLE;
            r_expected  <= '0;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
        end else if (data_valid) begin
            case (r_state)
                S_IDLE: begin
                    r_expected  <= w_next_exp;
                    r_match_cnt <= '0;
                    r_state     <= S_SYNC;
                    r_locked    <= 1'b0;
                end
                S_SYNC: begin
                    r_expected <= w_next_exp;
                    if (w_match) begin
                        r_match_cnt <= w_match_nxt;
                        if (w_lock_evt) begin
                            r_state  <= S_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else begin
                        r_match_cnt <= '0;
                    end
                end
                S_LOCKED: begin
                    r_expected <= w_next_exp;
                    r_locked   <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_expected  <= '0;
                    r_match_cnt <= '0;
                    r_locked    <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle mismatch pulse for a broken increment while locked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= w_err_evt;
        end
    end

    // Saturating count of every accepted word, in any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (clr) begin
            r_word_cnt <= '0;
        end else if (data_valid && !w_word_sat) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
    end

    // Saturating count of locked-state mismatches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (clr) begin
            r_err_cnt <= '0;
        end else if (w_err_evt && !w_err_sat) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    // Capture the first mismatch only; sticky flag freezes the snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_first_exp  <= '0;
            r_first_act  <= '0;
        end else if (clr) begin
            r_err_sticky <= 1'b0;
            r_first_exp  <= '0;
            r_first_act  <= '0;
        end else if (w_err_evt && !r_err_sticky) begin
            r_err_sticky <= 1'b1;
            r_first_exp  <= r_expected;
            r_first_act  <= data_in;
        end
    end

`ifdef FOO_SEQ_CHECKER_DISPLAY_EN
    // Console trace of accepted words, mismatches and lock entry
    always @(posedge clk) begin
        if (!rst && w_take) begin
            $display("data_in = 0x%x", data_in);
            if (w_err_evt) begin
                $error("foo_seq_checker: expected 0x%x got 0x%x",
                       r_expected, data_in);
            end
            if (w_lock_evt) begin
                $display("locked");
            end
        end
    end
`else
`endif

    assign locked     = r_locked;
    assign mismatch   = r_mismatch;
    assign err_sticky = r_err_sticky;
    assign word_cnt   = r_word_cnt;
    assign err_cnt    = r_err_cnt;
    assign first_exp  = r_first_exp;
    assign first_act  = r_first_act;

endmodule

// File: tb/tb_foo_seq_checker.sv
// Bench for foo_seq_checker: directed test plan steps followed by random
// stream traffic, all outputs compared against a behavioural model.
module tb_foo_seq_checker;

    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int LN   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          data_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          locked;
    logic          mismatch;
    logic          err_sticky;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] err_cnt;
    logic [DW-1:0] first_exp;
    logic [DW-1:0] first_act;

    foo_seq_checker #(.DATA_W(DW), .CNT_W(CW), .LOCK_N(LN)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .data_valid(data_valid), .data_in(data_in),
        .locked(locked), .mismatch(mismatch), .err_sticky(err_sticky),
        .word_cnt(word_cnt), .err_cnt(err_cnt),
        .first_exp(first_exp), .first_act(first_act)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: history of the stream, not an FSM copy
    bit          m_seen;
    logic [31:0] m_prev;
    int          m_run;
    bit          m_lock;
    bit          m_mm;
    bit          m_sticky;
    int          m_wc;
    int          m_ec;
    logic [31:0] m_fe;
    logic [31:0] m_fa;
    logic [31:0] last_sent;
    int          wc_before;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_seen = 0; m_prev = '0; m_run = 0; m_lock = 0; m_mm = 0;
        m_sticky = 0; m_wc = 0; m_ec = 0; m_fe = '0; m_fa = '0;
    endtask

    task automatic model_step(bit v, logic [31:0] d, bit c);
        logic [31:0] want;
        m_mm = 0;
        if (c) begin
            model_reset();
        end else if (v) begin
            want = m_prev + 32'd1;
            if (m_wc < CMAX) m_wc++;
            if (!m_seen) begin
                m_seen = 1;
                m_run  = 0;
            end else if (!m_lock) begin
                if (d == want) begin
                    m_run++;
                    if (m_run == LN) m_lock = 1;
                end else begin
                    m_run = 0;
                end
            end else if (d != want) begin
                m_mm = 1;
                if (m_ec < CMAX) m_ec++;
                if (!m_sticky) begin
                    m_sticky = 1;
                    m_fe = want;
                    m_fa = d;
                end
            end
            m_prev = d;
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".locked"}, 32'(locked), 32'(m_lock));
        chk({tag, ".mismatch"}, 32'(mismatch), 32'(m_mm));
        chk({tag, ".sticky"}, 32'(err_sticky), 32'(m_sticky));
        chk({tag, ".word_cnt"}, 32'(word_cnt), 32'(m_wc));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_ec));
        chk({tag, ".first_exp"}, first_exp, m_fe);
        chk({tag, ".first_act"}, first_act, m_fa);
    endtask

    task automatic step(bit v, logic [31:0] d, bit c, bit do_chk, string tag);
        data_valid = v;
        data_in    = d;
        clr        = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        data_valid = 1'b0;
        clr        = 1'b0;
        if (do_chk) check_all(tag);
    endtask

    task automatic word(logic [31:0] d, string tag);
        step(1'b1, d, 1'b0, 1'b1, tag);
    endtask

    task automatic all_zero(string tag);
        chk({tag, ".z_locked"}, 32'(locked), 32'd0);
        chk({tag, ".z_mm"}, 32'(mismatch), 32'd0);
        chk({tag, ".z_sticky"}, 32'(err_sticky), 32'd0);
        chk({tag, ".z_wc"}, 32'(word_cnt), 32'd0);
        chk({tag, ".z_ec"}, 32'(err_cnt), 32'd0);
        chk({tag, ".z_fe"}, first_exp, 32'd0);
        chk({tag, ".z_fa"}, first_act, 32'd0);
    endtask

    initial begin
        model_reset();
        // Reset state
        #1;
        all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("post_reset");

        // Lock on 0xcafedeca..0xcafeded3
        for (int i = 0; i < 10; i++) begin
            word(32'hcafedeca + 32'(i), "cafe");
            if (i == 1) chk("cafe.not_yet", 32'(locked), 32'd0);
            if (i == 2) chk("cafe.lock3", 32'(locked), 32'd1);
        end
        chk("cafe.wc10", 32'(word_cnt), 32'd10);
        chk("cafe.ec0", 32'(err_cnt), 32'd0);

        // First mismatch capture: 0x13 where 0x12 was due
        step(1'b0, '0, 1'b1, 1'b1, "clr1");
        word(32'h0e, "m1"); word(32'h0f, "m1"); word(32'h10, "m1");
        word(32'h11, "m1");
        word(32'h13, "m1");
        chk("m1.pulse", 32'(mismatch), 32'd1);
        chk("m1.fe", first_exp, 32'h12);
        chk("m1.fa", first_act, 32'h13);
        word(32'h14, "m1");
        chk("m1.no_pulse", 32'(mismatch), 32'd0);
        chk("m1.ec1", 32'(err_cnt), 32'd1);

        // Modulo wrap is a match
        step(1'b0, '0, 1'b1, 1'b1, "clr2");
        word(32'hfffffffe, "wrap"); word(32'hffffffff, "wrap");
        word(32'h0, "wrap");
        chk("wrap.lock", 32'(locked), 32'd1);
        word(32'h1, "wrap");
        chk("wrap.ec0", 32'(err_cnt), 32'd0);

        // Idle gap while locked
        step(1'b0, '0, 1'b1, 1'b1, "clr3");
        word(32'h1e, "gap"); word(32'h1f, "gap");
        wc_before = int'(word_cnt);
        word(32'h20, "gap");
        repeat (5) step(1'b0, 32'hdead, 1'b0, 1'b1, "gap_idle");
        word(32'h21, "gap");
        chk("gap.wc2", 32'(word_cnt), 32'(wc_before + 2));
        chk("gap.ec0", 32'(err_cnt), 32'd0);

        // Second mismatch leaves the capture untouched
        word(32'h25, "m2");
        for (int i = 'h26; i <= 'h30; i++) word(32'(i), "m2");
        word(32'h40, "m2");
        chk("m2.ec2", 32'(err_cnt), 32'd2);
        chk("m2.fe", first_exp, 32'h22);
        chk("m2.fa", first_act, 32'h25);
        step(1'b1, 32'h41, 1'b1, 1'b1, "clr_valid");
        all_zero("clr_valid");

        // Async reset mid-stream
        for (int i = 1; i <= 4; i++) word(32'(i), "pre_rst");
        word(32'h9, "pre_rst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        word(32'h5, "relock"); word(32'h6, "relock"); word(32'h7, "relock");
        chk("relock.lock", 32'(locked), 32'd1);
        chk("relock.ec0", 32'(err_cnt), 32'd0);

        // Counter saturation (counters are CW bits here)
        step(1'b0, '0, 1'b1, 1'b1, "clr4");
        for (int i = 0; i < CMAX + 20; i++)
            step(1'b1, 32'(i), 1'b0, (i % 16 == 0), "wsat");
        check_all("wsat_end");
        chk("wsat.cap", 32'(word_cnt), 32'(CMAX));
        for (int i = 0; i < CMAX + 20; i++)
            step(1'b1, 32'(1000 + 2 * i), 1'b0, (i % 16 == 0), "esat");
        check_all("esat_end");
        chk("esat.cap", 32'(err_cnt), 32'(CMAX));
        chk("esat.pulse", 32'(mismatch), 32'd1);

        // Random traffic
        step(1'b0, '0, 1'b1, 1'b1, "clr5");
        last_sent = $urandom;
        for (int i = 0; i < 1500; i++) begin
            int r;
            bit v;
            bit c;
            logic [31:0] d;
            v = ($urandom_range(0, 99) < 80);
            c = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 99);
            if (r < 8) d = $urandom;
            else if (r < 10) d = 32'hfffffffe;
            else d = last_sent + 32'd1;
            if (v && !c) last_sent = d;
            step(v, d, c, 1'b1, "rand");
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/foo_seq_checker.md
Name: foo_seq_checker

Overview:
- Receive-side endpoint of the foo_if data stream. The driver launches a 32-bit data_out word on each posedge clk; this block samples it on the same edge.
- Verifies the stream is a monotonically incrementing sequence (+1 per valid word, modulo 2^DATA_W), then reports lock status, error counts and the first mismatch.
- Sits beside the monitor on the foo_if consumer side; synthesizable for use in the bench and in emulation.

Parameters:
- DATA_W, 32, width of the data field carried on foo_if.
- CNT_W, 16, width of the word and error counters (both saturating).
- LOCK_N, 2, consecutive correct increments required in SYNC before entering LOCKED (range 1..15).

Ports:
- clk  input  1  stream clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous clear: counters, sticky flags and FSM return to IDLE.
- data_valid  input  1  sampled word is valid this cycle.
- data_in  input  DATA_W  sampled foo_if data_out.data.
- locked  output  1  FSM in LOCKED.
- mismatch  output  1  one-cycle pulse, registered, on any mismatch while LOCKED.
- err_sticky  output  1  set on first mismatch; held until rst or clr.
- word_cnt  output  CNT_W  valid words received since reset/clr; saturates at all-ones.
- err_cnt  output  CNT_W  mismatches while LOCKED; saturates at all-ones.
- first_exp  output  DATA_W  expected value at the first mismatch.
- first_act  output  DATA_W  received value at the first mismatch.

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; internal expected=0, match counter=0.
- All state updates on posedge clk. Outputs are registered and reflect a word one cycle after its sampling edge.
- IDLE: on data_valid, expected<=data_in+1, match_cnt<=0, go to SYNC.
- SYNC, valid word:
  - data_in==expected: match_cnt++; expected<=data_in+1; when match_cnt reaches LOCK_N, go to LOCKED (locked=1 the cycle after the LOCK_N-th match).
  - Mismatch: re-anchor (expected<=data_in+1, match_cnt<=0), stay in SYNC. No error counted.
- LOCKED, valid word:
  - data_in==expected: expected<=data_in+1.
  - Mismatch: mismatch=1 for one cycle; err_cnt++ (saturating). If err_sticky==0, capture first_exp<=expected, first_act<=data_in and set err_sticky. Re-anchor expected<=data_in+1; stay LOCKED.
- data_valid=0 in any state: no state, counter or expected change; mismatch=0.
- word_cnt increments on every valid word in every state, including the first word in IDLE.
- Arithmetic: expected is DATA_W-bit modulo. 0xFFFFFFFF followed by 0x00000000 is a match, not an error.
- Counter saturation: at all-ones, word_cnt and err_cnt hold. mismatch pulses and capture logic still operate.
- clr has priority over data_valid in the same cycle: everything cleared, state=IDLE, that cycle's word discarded and not counted.
- rst asserted mid-stream: immediate return to reset values. First valid word after deassertion is treated as in IDLE.
- first_exp/first_act change only at the first capture after rst/clr.

Optional Feature:
- Macro: FOO_SEQ_CHECKER_DISPLAY_EN.
- Defined (simulation only):
  - Each valid word prints "data_in = 0x%x".
  - Each mismatch in LOCKED prints $error with expected and actual values.
  - Entering LOCKED prints "locked".
- Undefined: no system tasks compiled; functionally identical otherwise.

Test Plan:
- Reset, then 10 valid words 0xcafedeca..0xcafeded3 -> locked=1 after the 3rd word (LOCK_N=2); word_cnt=10, err_cnt=0, err_sticky=0.
- Locked stream 0x10,0x11,0x13,0x14 -> one mismatch pulse at 0x13; err_cnt=1; first_exp=0x12, first_act=0x13. 0x14 accepted with no further error.
- Words 0xfffffffe,0xffffffff,0x0,0x1 -> lock achieved; no mismatch across the wrap.
- data_valid low for 5 cycles between 0x20 and 0x21 while locked -> no mismatch; word_cnt advances by 2 only.
- Second mismatch (expect 0x31, get 0x40) after a first one -> err_cnt=2; first_exp/first_act unchanged. Then clr together with data_valid -> all outputs 0, state IDLE, word not counted.
- Assert rst mid-LOCKED stream -> outputs 0 asynchronously. After release, 0x5,0x6,0x7 -> relocks with err_cnt=0.
